// File: rtl/pll_reconfig_ctrl_if.sv
// pll_reconfig_ctrl_if: request handshake between requester and PLL sequencer.
// Config code is sampled by the sequencer only on valid && ready.
interface pll_reconfig_ctrl_if;
  logic       req_valid_i;
  logic [2:0] req_cfg_i;
  logic       req_ready_o;

  modport master (
    output req_valid_i,
    output req_cfg_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_cfg_i,
    output req_ready_o
  );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: bypass, PLL reset + config, lock wait, switch back.
// Define PLL_LOCK_MON_EN to add the IDLE lock-loss monitor and lock_lost_o.
module pll_reconfig_ctrl #(
  parameter int SETTLE_CYC   = 16,
  parameter int RST_HOLD_CYC = 32,
  parameter int LOCK_TO_CYC  = 65536
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pll_reconfig_ctrl_if.slave req,
  input  logic               pll_lock_i,
  output logic [2:0]         pll_cfg_o,
  output logic               pll_rst_n_o,
  output logic               clk_bypass_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
`ifdef PLL_LOCK_MON_EN
  ,
  output logic               lock_lost_o
`endif
);

  localparam int MAX_A =
    (SETTLE_CYC > RST_HOLD_CYC) ? SETTLE_CYC : RST_HOLD_CYC;
  localparam int MAX_P =
    (MAX_A > LOCK_TO_CYC) ? MAX_A : LOCK_TO_CYC;
  localparam int CW = $clog2(MAX_P) + 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t SET_LIM = cnt_t'(SETTLE_CYC - 1);
  localparam cnt_t RST_LIM = cnt_t'(RST_HOLD_CYC - 1);
  localparam cnt_t TO_LIM  = cnt_t'(LOCK_TO_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    BYPASS,
    PRST,
    LOCKW,
    STABLE,
    SWITCH,
    DONE,
    FAIL
  } state_t;

  state_t     state;
  cnt_t       cnt;
  cnt_t       scnt;
  logic [2:0] cfg_q;
  logic       ready_q;
  logic       lock_m;
  logic       lock_s;
  logic       accept;

  assign req.req_ready_o = ready_q;
  assign accept = req.req_valid_i & ready_q;

  function automatic cnt_t sat_inc(cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

`ifdef PLL_LOCK_MON_EN
  logic lost_q;
  logic low_q;
  assign lock_lost_o = lost_q;
`endif

  // two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock_i;
      lock_s <= lock_m;
    end
  end

  // sequencer FSM; outputs registered alongside the next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      scnt         <= '0;
      cfg_q        <= 3'b000;
      ready_q      <= 1'b1;
      pll_cfg_o    <= 3'b000;
      pll_rst_n_o  <= 1'b0;
      clk_bypass_o <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
`ifdef PLL_LOCK_MON_EN
      lost_q       <= 1'b0;
      low_q        <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
`ifdef PLL_LOCK_MON_EN
      low_q <= (state == IDLE) & ~clk_bypass_o & ~lock_s;
`endif
      unique case (state)
        IDLE, FAIL: begin
          if (accept) begin
            state        <= BYPASS;
            cnt          <= '0;
            cfg_q        <= req.req_cfg_i;
            err_o        <= 1'b0;
            ready_q      <= 1'b0;
            busy_o       <= 1'b1;
            clk_bypass_o <= 1'b1;
`ifdef PLL_LOCK_MON_EN
            lost_q       <= 1'b0;
`endif
          end
`ifdef PLL_LOCK_MON_EN
          else if (state == IDLE && !clk_bypass_o
                   && !lock_s && low_q) begin
            state        <= FAIL;
            clk_bypass_o <= 1'b1;
            pll_rst_n_o  <= 1'b0;
            err_o        <= 1'b1;
            lost_q       <= 1'b1;
          end
`endif
        end
        BYPASS: begin
          if (cnt >= SET_LIM) begin
            state       <= PRST;
            cnt         <= '0;
            pll_rst_n_o <= 1'b0;
            pll_cfg_o   <= cfg_q;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        PRST: begin
          if (cnt >= RST_LIM) begin
            cnt <= '0;
            if (cfg_q[2:1] == 2'b00) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state       <= LOCKW;
              pll_rst_n_o <= 1'b1;
            end
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        LOCKW: begin
          if (cnt >= TO_LIM) begin
            state        <= FAIL;
            busy_o       <= 1'b0;
            ready_q      <= 1'b1;
            clk_bypass_o <= 1'b1;
            pll_rst_n_o  <= 1'b0;
            err_o        <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
            if (lock_s) begin
              state <= STABLE;
              scnt  <= '0;
            end
          end
        end
        STABLE: begin
          if (lock_s && scnt >= SET_LIM) begin
            state        <= SWITCH;
            cnt          <= '0;
            clk_bypass_o <= 1'b0;
          end else if (cnt >= TO_LIM) begin
            state        <= FAIL;
            busy_o       <= 1'b0;
            ready_q      <= 1'b1;
            clk_bypass_o <= 1'b1;
            pll_rst_n_o  <= 1'b0;
            err_o        <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
            if (!lock_s) begin
              state <= LOCKW;
            end else begin
              scnt <= sat_inc(scnt);
            end
          end
        end
        SWITCH: begin
          if (cnt >= SET_LIM) begin
            state  <= DONE;
            cnt    <= '0;
            done_o <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        DONE: begin
          state   <= IDLE;
          cnt     <= '0;
          busy_o  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
